// File: rtl/adc_capture_sequencer_pkg.sv
// Package ising_config: shared sizes, GPIO field layout, register offsets and
// types for the ADC capture sequencer.
package ising_config;

  localparam int num_bits = 16;

  localparam int gpio_addr_lsb  = 0;
  localparam int gpio_addr_w    = 16;
  localparam int gpio_data_lsb  = 16;
  localparam int gpio_data_w    = 8;
  localparam int gpio_w_clk_bit = 24;

  localparam logic [15:0] ADC_SEQ_REG_DELAY   = 16'd0;
  localparam logic [15:0] ADC_SEQ_REG_WIN_LEN = 16'd1;
  localparam logic [15:0] ADC_SEQ_REG_NWIN_LO = 16'd2;
  localparam logic [15:0] ADC_SEQ_REG_NWIN_HI = 16'd3;
  localparam logic [15:0] ADC_SEQ_REG_CTRL    = 16'd4;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    WINDOW,
    WAIT_RES,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [7:0]  delay;
    logic [7:0]  win_len;
    logic [15:0] num_windows;
  } seq_cfg_t;

  function automatic logic [15:0] windows_or_one(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Experiment-FSM side of the capture sequencer: start/busy/done handshake,
// sticky error and the forwarded result stream.
interface adc_capture_sequencer_if #(
  parameter int num_bits = ising_config::num_bits
);
  logic                start;
  logic                busy;
  logic                done;
  logic                err;
  logic [num_bits-1:0] res_out;
  logic                res_valid;
  logic [15:0]         res_cnt;

  modport master (output start, input busy, done, err, res_out, res_valid, res_cnt);
  modport slave  (input start, output busy, done, err, res_out, res_valid, res_cnt);
endinterface

// File: rtl/adc_capture_sequencer_cfg_regs.sv
// seq_cfg_regs: GPIO config registers (w_clk synchronizer, address decode,
// reset defaults) plus the copy taken when a round is accepted.
module seq_cfg_regs
  import ising_config::*;
#(
  parameter int base_addr = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  input  logic        capture,
  output seq_cfg_t    shadow,
  output logic        raw_arm
);

  logic [2:0]  w_sync;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        wr;
  seq_cfg_t    live;
  logic        unused_gpio;

  assign addr        = gpio_in[gpio_addr_lsb +: gpio_addr_w];
  assign data        = gpio_in[gpio_data_lsb +: gpio_data_w];
  assign wr          = w_sync[1] & ~w_sync[2];
  assign unused_gpio = ^gpio_in[31:gpio_w_clk_bit+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_sync <= '0;
    else      w_sync <= {w_sync[1:0], gpio_in[gpio_w_clk_bit]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live.delay       <= '0;
      live.win_len     <= 8'd1;
      live.num_windows <= 16'd1;
      raw_arm          <= 1'b0;
    end else if (wr) begin
      if (addr == 16'(base_addr) + ADC_SEQ_REG_DELAY)
        live.delay <= data;
      else if (addr == 16'(base_addr) + ADC_SEQ_REG_WIN_LEN)
        live.win_len <= (data == 8'd0) ? 8'd1 : data;
      else if (addr == 16'(base_addr) + ADC_SEQ_REG_NWIN_LO)
        live.num_windows[7:0] <= data;
      else if (addr == 16'(base_addr) + ADC_SEQ_REG_NWIN_HI)
        live.num_windows[15:8] <= data;
      else if (addr == 16'(base_addr) + ADC_SEQ_REG_CTRL)
        raw_arm <= data[0];
    end
  end

  // num_windows=0 is folded to 1 here so the FSM never sees zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow.delay       <= '0;
      shadow.win_len     <= 8'd1;
      shadow.num_windows <= 16'd1;
    end else if (capture) begin
      shadow.delay       <= live.delay;
      shadow.win_len     <= live.win_len;
      shadow.num_windows <= windows_or_one(live.num_windows);
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// ADC capture round sequencer: delay / run-window / result-collection FSM.
// Optional WAIT_RES timeout enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_capture_sequencer
  import ising_config::*;
#(
  parameter int base_addr      = 16,
  parameter int num_bits       = ising_config::num_bits,
  parameter int timeout_cycles = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             gpio_in,
  adc_capture_sequencer_if.slave  bus,
  output logic                    scaler_run,
  output logic                    del_trig,
  input  logic [num_bits-1:0]     val_in,
  input  logic                    val_in_valid
);

  localparam int tmo_w = $clog2(timeout_cycles + 1);
  localparam int cnt_w = (tmo_w > 8) ? tmo_w : 8;

  seq_state_t          state;
  seq_cfg_t            shadow;
  logic                raw_arm;
  logic                capture;
  logic                accept;
  logic                busy, done, err, res_valid;
  logic [num_bits-1:0] res_out;
  logic [15:0]         res_cnt, win_res, wins_done;
  logic [cnt_w-1:0]    cnt;

  assign capture = (state == IDLE) & bus.start;
  assign accept  = busy & val_in_valid;

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.res_out   = res_out;
  assign bus.res_valid = res_valid;
  assign bus.res_cnt   = res_cnt;

  seq_cfg_regs #(.base_addr(base_addr)) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .capture (capture),
    .shadow  (shadow),
    .raw_arm (raw_arm)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      scaler_run <= 1'b0;
      del_trig   <= 1'b0;
      res_out    <= '0;
      res_valid  <= 1'b0;
      res_cnt    <= '0;
      win_res    <= '0;
      wins_done  <= '0;
      cnt        <= '0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      if (accept) begin
        res_out   <= val_in;
        res_valid <= 1'b1;
        if (res_cnt != 16'hFFFF) res_cnt <= res_cnt + 16'd1;
        if (win_res != 16'hFFFF) win_res <= win_res + 16'd1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= DELAY;
            busy      <= 1'b1;
            del_trig  <= raw_arm;
            err       <= 1'b0;
            res_cnt   <= '0;
            win_res   <= '0;
            wins_done <= '0;
            cnt       <= '0;
          end
        end

        DELAY: begin
          if (cnt == cnt_w'(shadow.delay)) begin
            state      <= WINDOW;
            scaler_run <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WINDOW: begin
          if (cnt == cnt_w'(shadow.win_len - 8'd1)) begin
            state      <= WAIT_RES;
            scaler_run <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A result landing in the same cycle as the window hand-off belongs
        // to the next window, hence the reload of win_res with accept.
        WAIT_RES: begin
          if (win_res >= {8'd0, shadow.win_len}) begin
            if (wins_done + 16'd1 < shadow.num_windows) begin
              state     <= DELAY;
              wins_done <= wins_done + 16'd1;
              win_res   <= accept ? 16'd1 : 16'd0;
              cnt       <= '0;
            end else begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              del_trig <= 1'b0;
            end
          end
`ifdef ADC_SEQ_TIMEOUT_EN
          else if (cnt == cnt_w'(timeout_cycles - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            del_trig <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          else begin
            cnt <= '0;
          end
`endif
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer with a 2-cycle ADC response model
// and a result scoreboard.
module tb_adc_capture_sequencer;

  localparam int NB   = ising_config::num_bits;
  localparam int BASE = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   gpio_in = '0;
  logic          scaler_run, del_trig;
  logic [NB-1:0] val_in = '0;
  logic          val_in_valid = 1'b0;

  adc_capture_sequencer_if #(.num_bits(NB)) bus ();

  adc_capture_sequencer #(
    .base_addr      (BASE),
    .num_bits       (NB),
    .timeout_cycles (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .bus          (bus),
    .scaler_run   (scaler_run),
    .del_trig     (del_trig),
    .val_in       (val_in),
    .val_in_valid (val_in_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [NB-1:0] exp_q[$];
  logic          adc_en = 1'b1;
  logic [1:0]    hist = '0;

  int   busy_at0, first_run, run_cyc, run_pulses, run_fall, del_mis;
  int   done_cnt, done_at, busy_rises;
  logic [15:0] res_at_done;
  logic err_at_done, err_at0, done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ADC model: one result per run cycle, two cycles later
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      hist         = '0;
      val_in_valid = 1'b0;
    end else begin
      val_in_valid = adc_en & hist[1];
      if (val_in_valid) begin
        val_in = NB'($urandom);
        exp_q.push_back(val_in);
      end
      hist = {hist[0], scaler_run};
    end
  end

  always @(negedge clk) begin
    if (rst && bus.res_valid) begin
      check("res_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("res_out", 32'(bus.res_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic wr_cfg(input logic [15:0] off, input logic [7:0] d);
    gpio_in = {7'd0, 1'b0, d, 16'(BASE) + off};
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic observe(input int max_cyc, input int restart_at, input int wr_at,
                         input logic [7:0] wr_data, input logic raw);
    logic prev_run, prev_busy;
    int   tail;
    busy_at0 = int'(bus.busy); err_at0 = bus.err;
    first_run = -1; run_cyc = 0; run_pulses = 0; run_fall = -1; del_mis = 0;
    done_cnt = 0; done_at = -1; busy_rises = 0; res_at_done = '0; err_at_done = 1'b0;
    prev_run = 1'b0; prev_busy = bus.busy; tail = -1;
    for (int i = 0; i < max_cyc; i++) begin
      bus.start = (i == restart_at);
      if (i == wr_at) gpio_in = {7'd0, 1'b1, wr_data, 16'(BASE + 1)};
      else if (wr_at >= 0 && i == wr_at + 4) gpio_in[24] = 1'b0;
      if (scaler_run && !prev_run) begin
        run_pulses++;
        if (first_run < 0) first_run = i;
      end
      if (!scaler_run && prev_run) run_fall = i;
      if (scaler_run) run_cyc++;
      if (del_trig !== (bus.busy & raw)) del_mis++;
      if (bus.busy && !prev_busy) busy_rises++;
      if (bus.done) begin
        done_cnt++; done_at = i; res_at_done = bus.res_cnt; err_at_done = bus.err;
        if (tail < 0) tail = i + 4;
      end
      prev_run = scaler_run; prev_busy = bus.busy;
      if (i == tail) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    done_seen = (done_cnt > 0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_run", scaler_run, 0);
    check("rst_del_trig", del_trig, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_cnt", bus.res_cnt, 0);
    check("rst_res_out", 32'(bus.res_out), 0);
    rst = 1'b1;
    @(negedge clk);

    // round 1: delay 3, one window of 4, no raw arm
    wr_cfg(0, 8'd3); wr_cfg(1, 8'd4); wr_cfg(2, 8'd1); wr_cfg(3, 8'd0); wr_cfg(4, 8'd0);
    pulse_start();
    observe(60, -1, -1, 8'd0, 1'b0);
    check("r1_done_seen", done_seen, 1);
    check("r1_busy_rise", busy_at0, 1);
    check("r1_first_run", first_run, 4);
    check("r1_run_cycles", run_cyc, 4);
    check("r1_run_pulses", run_pulses, 1);
    check("r1_del_trig", del_mis, 0);
    check("r1_done_pulses", done_cnt, 1);
    check("r1_res_cnt", res_at_done, 4);
    check("r1_q_empty", exp_q.size(), 0);

    // round 2: raw arm, three windows of 2
    wr_cfg(1, 8'd2); wr_cfg(2, 8'd3); wr_cfg(4, 8'd1);
    pulse_start();
    observe(120, -1, -1, 8'd0, 1'b1);
    check("r2_done_seen", done_seen, 1);
    check("r2_del_trig_vs_busy", del_mis, 0);
    check("r2_run_pulses", run_pulses, 3);
    check("r2_run_cycles", run_cyc, 6);
    check("r2_res_cnt", res_at_done, 6);
    check("r2_done_pulses", done_cnt, 1);

    // round 3: zero win_len/num_windows act as 1; restart while busy ignored
    wr_cfg(0, 8'd0); wr_cfg(1, 8'd0); wr_cfg(2, 8'd0); wr_cfg(3, 8'd0); wr_cfg(4, 8'd0);
    pulse_start();
    observe(40, 2, -1, 8'd0, 1'b0);
    check("r3_first_run", first_run, 1);
    check("r3_run_cycles", run_cyc, 1);
    check("r3_run_pulses", run_pulses, 1);
    check("r3_res_cnt", res_at_done, 1);
    check("r3_done_pulses", done_cnt, 1);
    check("r3_busy_rerise", busy_rises, 0);

    // round 4/5: win_len written 4->8 mid-round
    wr_cfg(0, 8'd1); wr_cfg(1, 8'd4);
    pulse_start();
    observe(60, -1, 1, 8'd8, 1'b0);
    check("r4_first_run", first_run, 2);
    check("r4_run_cycles", run_cyc, 4);
    check("r4_res_cnt", res_at_done, 4);
    repeat (3) @(negedge clk);
    pulse_start();
    observe(60, -1, -1, 8'd0, 1'b0);
    check("r5_run_cycles", run_cyc, 8);
    check("r5_res_cnt", res_at_done, 8);
    check("r5_q_empty", exp_q.size(), 0);

    // round 6: withheld results
    wr_cfg(0, 8'd0); wr_cfg(1, 8'd2);
    adc_en = 1'b0;
    pulse_start();
    observe(50, -1, -1, 8'd0, 1'b0);
`ifdef ADC_SEQ_TIMEOUT_EN
    check("r6_done_seen", done_seen, 1);
    check("r6_err_at_done", err_at_done, 1);
    check("r6_timeout_cycles", done_at - run_fall, 16);
    check("r6_res_cnt", res_at_done, 0);
    check("r6_err_sticky", bus.err, 1);
    adc_en = 1'b1;
    pulse_start();
    observe(60, -1, -1, 8'd0, 1'b0);
    check("r6b_err_cleared", err_at0, 0);
    check("r6b_done_seen", done_seen, 1);
    check("r6b_res_cnt", res_at_done, 2);
`else
    check("r6_no_done", done_cnt, 0);
    check("r6_busy_held", bus.busy, 1);
    check("r6_err_zero", bus.err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    adc_en = 1'b1;
    @(negedge clk);
`endif

    // round 7: asynchronous reset mid-window, then defaults
    wr_cfg(0, 8'd0); wr_cfg(1, 8'd8); wr_cfg(4, 8'd1);
    pulse_start();
    for (int n = 0; n < 20 && !scaler_run; n++) @(negedge clk);
    check("r7_in_window", scaler_run, 1);
    check("r7_del_trig_armed", del_trig, 1);
    #2 rst = 1'b0;
    #1;
    check("r7_async_run", scaler_run, 0);
    check("r7_async_del_trig", del_trig, 0);
    check("r7_async_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    pulse_start();
    observe(40, -1, -1, 8'd0, 1'b0);
    check("r8_done_seen", done_seen, 1);
    check("r8_default_first_run", first_run, 1);
    check("r8_default_win_len", run_cyc, 1);
    check("r8_default_raw_arm", del_mis, 0);
    check("r8_res_cnt", res_at_done, 1);
    check("r8_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
Sequences the ADC capture path for each Ising spin round. Drives the peak-detector run window (adc_input_scaler_run) and the raw-buffer trigger (del_trig) with programmed timing. Collects lookup-table results and hands them to the experiment FSM over a start/busy/done handshake. Sits between the experiment FSM and adc_driver. Configured over the shared 32-bit GPIO bus.

Parameters:
base_addr, 16, first GPIO config address; occupies base_addr..base_addr+4
num_bits, ising_config::num_bits, width of result values
timeout_cycles, 1023, WAIT_RES timeout; used only with the macro below

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
gpio_in  in  32  GPIO bus: [15:0] addr, [23:16] data, [24] w_clk
start  in  1  single-cycle pulse from experiment FSM; begins one round
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse at end of round
err  out  1  sticky timeout flag; cleared by next accepted start
scaler_run  out  1  connects to adc_driver adc_input_scaler_run
del_trig  out  1  connects to adc_driver del_trig (level)
val_in  in  num_bits  adc_driver val_out
val_in_valid  in  1  adc_driver val_valid
res_out  out  num_bits  last accepted result
res_valid  out  1  one-cycle strobe per forwarded result
res_cnt  out  16  results received this round

Behaviour:
- Reset: all outputs 0. State IDLE. Config registers: delay=0, win_len=1, num_windows=1, ctrl=0.
- Config writes: w_clk is passed through a 2-flop synchronizer. On its rising edge, gpio data is written to the matching address:
  - base+0 = delay[7:0]
  - base+1 = win_len[7:0] (a write of 0 is stored as 1)
  - base+2 = num_windows[7:0]
  - base+3 = num_windows[15:8]
  - base+4 = ctrl (bit0 raw_arm)
- Config is sampled into shadow registers on the accepted start. Writes during busy do not affect the current round.
- FSM states: IDLE, DELAY, WINDOW, WAIT_RES, DONE.
- IDLE:
  - start is accepted only here, and busy rises the next cycle.
  - If raw_arm, del_trig goes high in the same cycle busy rises.
  - Next state is DELAY, with the delay counter loaded. A start pulse while busy is ignored.
- DELAY: counts down delay cycles; delay=0 means 0 wait cycles. Then enters WINDOW.
- WINDOW: scaler_run is high for exactly win_len consecutive cycles. Then enters WAIT_RES.
- WAIT_RES:
  - Waits until this window's result count reaches win_len.
  - Then, if windows_done < num_windows, returns to DELAY; otherwise goes to DONE.
  - num_windows=0 is treated as 1.
- Results:
  - Every val_in_valid cycle while busy registers val_in into res_out, pulses res_valid 1 cycle later, and increments res_cnt. Latency is 1 cycle.
  - res_cnt saturates at 16'hFFFF.
  - val_in_valid outside busy is dropped.
  - val_in_valid arriving in DELAY/WINDOW counts toward the current window.
- DONE:
  - busy falls, done pulses 1 cycle, and del_trig returns low.
  - Return to IDLE.
  - Because of DONE, del_trig is guaranteed low for at least 1 cycle before the next start, so adc_driver can re-arm.
- Reset mid-round: everything returns to reset values immediately. Config registers are also reset.

Optional Feature:
- ADC_SEQ_TIMEOUT_EN defined:
  - WAIT_RES runs a counter.
  - If timeout_cycles elapse without reaching win_len results, err sets and the FSM goes to DONE (done still pulses).
- Undefined: no counter; WAIT_RES waits indefinitely and err is tied 0.

Decomposition:
- ising_config holds:
  - the seq_state_t enum;
  - gpio_w_clk_bit / addr / data field constants;
  - ADC_SEQ_REG_* address offsets.
- One sub-module: seq_cfg_regs (w_clk synchronizer, address decode, reset values, start-time shadow copy).

Test Plan:
- Config delay=3, win_len=4, num_windows=1, raw_arm=0; start; adc model returns 4 valids 2 cycles after run -> scaler_run high exactly 4 cycles starting 4 cycles after busy rises; res_cnt=4; done pulses once; del_trig stays 0.
- raw_arm=1, num_windows=3, win_len=2 -> del_trig high from busy rise through DONE, then low ≥1 cycle; three 2-cycle run windows; res_cnt=6.
- Write win_len=0 and num_windows=0 -> behaves as 1/1; a second start during busy is ignored (res_cnt unchanged, one done).
- Config write during busy (win_len 4->8) -> current round uses 4; next round uses 8.
- Withhold val_in_valid with ADC_SEQ_TIMEOUT_EN, timeout_cycles=16 -> err=1 and done 16 cycles after WAIT_RES entry; next start clears err. Without the macro: busy held indefinitely.
- Assert rst low mid-WINDOW -> scaler_run, del_trig, and busy go 0 asynchronously; after release, config reads back defaults (win_len=1).
